next_bit: RTL and testbench

Bit-serial front end of the Huffman decoder, the decode-side counterpart of the encoder's byte fetcher. Pops encoded bytes from the input FIFO (single-cycle read latency) and presents them MSB-first, one bit per handshake, to the code-tree walker. Honors a final-byte pad count so trailing pad bits are never delivered, then flags end of stream.

---
 rtl/next_bit.sv | 172 +++++++++++++++++
 tb/tb_next_bit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/next_bit.sv
`default_nettype none
// ============================================================================
//  Module      : next_bit
//  Description : Bit-serial front end of the Huffman decoder. Pops encoded
//                bytes from a single-cycle-latency FIFO and presents them
//                MSB-first, one bit per valid/ready handshake. Pad bits in
//                the final byte are never delivered; stream_done flags the
//                end of the stream.
//                Optional feature macro: NEXT_BIT_BITCNT_EN adds the 16-bit
//                saturating bit_cnt output (bits consumed since reset).
//  Revision    : 1.0  initial release
// ============================================================================
module next_bit #(
    parameter int PAD_W = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [7:0]       data,
    input  logic             last,
    input  logic [PAD_W-1:0] pad,
    input  logic             empty,
    output logic             r_en,
    output logic             bit_out,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             stream_done
`ifdef NEXT_BIT_BITCNT_EN
    ,
    output logic [15:0]      bit_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q,    state_d;
    logic [7:0] sr_q,       sr_d;
    logic [3:0] cnt_q,      cnt_d;
    logic [7:0] hb_q,       hb_d;
    logic [3:0] hb_cnt_q,   hb_cnt_d;
    logic       hb_valid_q, hb_valid_d;
    logic       rd_pend_q,  rd_pend_d;
    logic       done_q,     done_d;

    logic       w_take;
    logic       w_sr_free;
    logic       w_capture;
    logic [3:0] w_pad4;
    logic [3:0] w_load_cnt;

    // A byte is only fetched while running and when both the read pipe and
    // the holding register are free, so a capture always has somewhere to go.
    assign r_en        = (state_q == S_RUN) & ~empty & ~rd_pend_q & ~hb_valid_q;
    assign b_valid     = (cnt_q != 4'd0);
    assign bit_out     = sr_q[7];
    assign stream_done = done_q;

    assign w_take      = b_valid & b_ready;
    // The shift register can accept a new byte this edge if it is empty or
    // its final bit is being consumed right now (keeps back-to-back bytes
    // bubble-free).
    assign w_sr_free   = (cnt_q == 4'd0) | ((cnt_q == 4'd1) & w_take);
    // FIFO data is valid exactly one cycle after the pop.
    assign w_capture   = rd_pend_q;
    assign w_pad4      = 4'(pad);
    assign w_load_cnt  = last ? (4'd8 - w_pad4) : 4'd8;

    // Next-state logic for the stream FSM, shift register and holding register.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        hb_d       = hb_q;
        hb_cnt_d   = hb_cnt_q;
        hb_valid_d = hb_valid_q;
        rd_pend_d  = r_en;
        done_d     = done_q;

        if (w_take) begin
            sr_d  = {sr_q[6:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end

        // A waiting byte in the holding register has priority for the
        // shift register over a freshly captured one.
        if (hb_valid_q && w_sr_free) begin
            sr_d       = hb_q;
            cnt_d      = hb_cnt_q;
            hb_valid_d = 1'b0;
        end

        if (w_capture) begin
            if (w_sr_free && !hb_valid_q) begin
                sr_d  = data;
                cnt_d = w_load_cnt;
            end else begin
                hb_d       = data;
                hb_cnt_d   = w_load_cnt;
                hb_valid_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (w_capture && last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Finished once the holding register is empty and the very
                // last remaining bit is accepted.
                if (!hb_valid_q && (cnt_q == 4'd1) && w_take) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards everything including an in-flight pop.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q    <= S_IDLE;
            sr_q       <= 8'd0;
            cnt_q      <= 4'd0;
            hb_q       <= 8'd0;
            hb_cnt_q   <= 4'd0;
            hb_valid_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            hb_q       <= hb_d;
            hb_cnt_q   <= hb_cnt_d;
            hb_valid_q <= hb_valid_d;
            rd_pend_q  <= rd_pend_d;
            done_q     <= done_d;
        end
    end

`ifdef NEXT_BIT_BITCNT_EN
    logic [15:0] bit_cnt_q, bit_cnt_d;

    assign bit_cnt   = bit_cnt_q;
    assign bit_cnt_d = (w_take && (bit_cnt_q != 16'hFFFF)) ? (bit_cnt_q + 16'd1) : bit_cnt_q;

    // Saturating count of accepted bits; only reset clears it.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            bit_cnt_q <= 16'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_next_bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_next_bit
//  Description : Self-checking bench for next_bit. A FIFO model with one-cycle
//                read latency feeds the DUT; the expected bit stream is built
//                directly from the pushed bytes and their pad counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_next_bit;

    localparam int PAD_W = 3;

    typedef struct packed {
        logic [7:0]       dat;
        logic             lst;
        logic [PAD_W-1:0] pd;
    } ent_t;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic [7:0]       data;
    logic             last;
    logic [PAD_W-1:0] pad;
    logic             empty;
    logic             r_en;
    logic             bit_out;
    logic             b_valid;
    logic             b_ready;
    logic             stream_done;
`ifdef NEXT_BIT_BITCNT_EN
    logic [15:0]      bit_cnt;
`endif

    next_bit #(.PAD_W(PAD_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .data        (data),
        .last        (last),
        .pad         (pad),
        .empty       (empty),
        .r_en        (r_en),
        .bit_out     (bit_out),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .stream_done (stream_done)
`ifdef NEXT_BIT_BITCNT_EN
        ,
        .bit_cnt     (bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    ent_t fifo[$];
    bit   got[$];
    bit   expq[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_ren, hold_err, underrun;
    int   first_acc, last_acc, done_cyc, first_valid;
    int   rdy_mode, stall_pct;
    logic stall;
    logic s_valid, s_ready, s_bit, s_ren, s_done;
    logic prev_v, prev_r, prev_b, prev_rst;

    // Reference model: a byte contributes its top (8 - pad) bits if last, else 8.
    task automatic push_byte(input logic [7:0] d, input logic l, input logic [PAD_W-1:0] p);
        ent_t e;
        int   nb;
        e.dat = d; e.lst = l; e.pd = p;
        fifo.push_back(e);
        nb = l ? (8 - int'(p)) : 8;
        for (int i = 0; i < nb; i++) expq.push_back(d[7-i]);
        empty = stall || (fifo.size() == 0);
    endtask

    // One clock: sample outputs at negedge, then model the FIFO and drive inputs.
    task automatic tick();
        ent_t e;
        bit   pop;
        @(negedge clk);
        cyc++;
        s_valid = b_valid; s_ready = b_ready; s_bit = bit_out;
        s_ren = r_en; s_done = stream_done;
        if (!prev_rst && prev_v && !prev_r && (!s_valid || (s_bit !== prev_b))) hold_err++;
        if (s_valid && s_ready) begin
            got.push_back(s_bit);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (s_valid && first_valid < 0) first_valid = cyc;
        if (s_done && done_cyc < 0) done_cyc = cyc;
        if (s_ren) n_ren++;
        pop = s_ren;
        prev_v = s_valid; prev_r = s_ready; prev_b = s_bit; prev_rst = n_rst;
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) begin
            e = fifo.pop_front();
            data = e.dat; last = e.lst; pad = e.pd;
        end else begin
            if (pop) underrun++;
            data = 8'($urandom); last = 1'($urandom); pad = PAD_W'($urandom);
        end
        case (rdy_mode)
            0:       b_ready = 1'b1;
            1:       b_ready = 1'($urandom_range(0, 1));
            default: b_ready = ~b_ready;
        endcase
        stall = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
        empty = stall || (fifo.size() == 0);
    endtask

    task automatic clear_mon();
        fifo.delete(); got.delete(); expq.delete();
        n_ren = 0; hold_err = 0; underrun = 0;
        first_acc = -1; last_acc = -1; done_cyc = -1; first_valid = -1;
        s_done = 1'b0;
        stall = 1'b0;
        empty = 1'b1;
    endtask

    task automatic reset_dut();
        rdy_mode = 0; stall_pct = 0; b_ready = 1'b1; start = 1'b0;
        n_rst = 1'b1;
        tick(); tick();
        n_rst = 1'b0;
        clear_mon();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !s_done; i++) tick();
    endtask

    task automatic test_reset();
        int bad;
        rdy_mode = 0; stall_pct = 0; b_ready = 1'b1; start = 1'b0;
        n_rst = 1'b1;
        clear_mon();
        tick(); tick();
        n_cmp++;
        if ({s_ren, s_valid, s_bit, s_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: r_en/b_valid/bit_out/done got %b want 0000",
                     {s_ren, s_valid, s_bit, s_done});
        end
`ifdef NEXT_BIT_BITCNT_EN
        n_cmp++;
        if (bit_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_bitcnt: got %0d want 0", bit_cnt);
        end
`endif
        // Reset mid-stream while a pop is in flight and a byte is shifting out.
        n_rst = 1'b0;
        clear_mon();
        push_byte(8'hA5, 1'b0, 3'd0);
        push_byte(8'h3C, 1'b1, 3'd0);
        pulse_start();
        tick(); tick(); tick();
        n_rst = 1'b1;
        tick();
        n_cmp++;
        if ({s_valid, s_ren} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_prestate: b_valid/r_en got %b want 10", {s_valid, s_ren});
        end
        tick();
        n_cmp++;
        if ({s_ren, s_valid, s_bit, s_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_midstream: r_en/b_valid/bit_out/done got %b want 0000",
                     {s_ren, s_valid, s_bit, s_done});
        end
        // Clean restart after reset.
        n_rst = 1'b0;
        clear_mon();
        push_byte(8'h96, 1'b1, 3'd1);
        pulse_start();
        wait_done(60);
        bad = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) bad++;
        n_cmp++;
        if (!s_done || got.size() != expq.size() || bad != 0) begin
            n_err++;
            $display("FAIL reset_restart: done=%b bits=%0d bad=%0d want done=1 bits=%0d bad=0",
                     s_done, got.size(), bad, expq.size());
        end
    endtask

    task automatic test_two_bytes();
        int st, bad;
        reset_dut();
        push_byte(8'hA5, 1'b0, 3'd0);
        push_byte(8'h3C, 1'b1, 3'd0);
        pulse_start();
        st = cyc;
        wait_done(60);
        bad = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) bad++;
        n_cmp++;
        if (!s_done || got.size() != 16 || expq.size() != 16 || bad != 0) begin
            n_err++;
            $display("FAIL two_bytes_stream: done=%b bits=%0d bad=%0d want done=1 bits=16 bad=0",
                     s_done, got.size(), bad);
        end
        n_cmp++;
        if (n_ren != 2) begin
            n_err++;
            $display("FAIL two_bytes_ren: got %0d pops want 2", n_ren);
        end
        n_cmp++;
        if (first_valid - st != 3) begin
            n_err++;
            $display("FAIL two_bytes_latency: got %0d cycles want 3", first_valid - st);
        end
        n_cmp++;
        if (last_acc - first_acc != 15) begin
            n_err++;
            $display("FAIL two_bytes_gapless: span got %0d want 15", last_acc - first_acc);
        end
        n_cmp++;
        if (done_cyc != last_acc + 1) begin
            n_err++;
            $display("FAIL two_bytes_done_timing: got cycle %0d want %0d", done_cyc, last_acc + 1);
        end
    endtask

    task automatic test_pad();
        reset_dut();
        push_byte(8'hF0, 1'b1, 3'd5);
        pulse_start();
        wait_done(40);
        n_cmp++;
        if (!s_done || got.size() != 3 || got[0] != 1'b1 || got[1] != 1'b1 || got[2] != 1'b1) begin
            n_err++;
            $display("FAIL pad5_stream: done=%b bits=%0d want done=1 bits=3 all ones",
                     s_done, got.size());
        end
`ifdef NEXT_BIT_BITCNT_EN
        n_cmp++;
        if (bit_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL pad5_bitcnt: got %0d want 3", bit_cnt);
        end
`endif
        reset_dut();
        push_byte(8'h80, 1'b1, 3'd7);
        pulse_start();
        wait_done(40);
        n_cmp++;
        if (!s_done || got.size() != 1 || got[0] != 1'b1) begin
            n_err++;
            $display("FAIL pad7_stream: done=%b bits=%0d want done=1 bits=1", s_done, got.size());
        end
    endtask

    task automatic test_backpressure();
        int bad;
        reset_dut();
        rdy_mode = 2;
        push_byte(8'h81, 1'b1, 3'd0);
        pulse_start();
        wait_done(80);
        bad = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) bad++;
        n_cmp++;
        if (!s_done || got.size() != 8 || bad != 0) begin
            n_err++;
            $display("FAIL backpressure_stream: done=%b bits=%0d bad=%0d want done=1 bits=8 bad=0",
                     s_done, got.size(), bad);
        end
        n_cmp++;
        if (hold_err != 0) begin
            n_err++;
            $display("FAIL backpressure_hold: got %0d hold violations want 0", hold_err);
        end
    endtask

    task automatic test_underflow();
        int bad, m;
        reset_dut();
        push_byte(8'h5A, 1'b0, 3'd0);
        pulse_start();
        repeat (11) tick();
        bad = 0;
        repeat (10) begin
            tick();
            if (s_valid || s_ren) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL underflow_idle: got %0d active cycles want 0", bad);
        end
        push_byte(8'hC3, 1'b1, 3'd2);
        m = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_valid) break;
        end
        n_cmp++;
        if (!s_valid || cyc - m != 2) begin
            n_err++;
            $display("FAIL underflow_resume: valid=%b after %0d cycles want 2", s_valid, cyc - m);
        end
        wait_done(40);
        bad = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) bad++;
        n_cmp++;
        if (!s_done || got.size() != 14 || bad != 0 || n_ren != 2) begin
            n_err++;
            $display("FAIL underflow_stream: done=%b bits=%0d bad=%0d pops=%0d want 1/14/0/2",
                     s_done, got.size(), bad, n_ren);
        end
    endtask

    task automatic test_start_ignored();
        int bad;
        reset_dut();
        push_byte(8'h12, 1'b0, 3'd0);
        push_byte(8'hE7, 1'b0, 3'd3);
        push_byte(8'h6B, 1'b1, 3'd4);
        pulse_start();
        repeat (5) tick();
        pulse_start();
        wait_done(80);
        bad = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) bad++;
        n_cmp++;
        if (!s_done || got.size() != expq.size() || bad != 0 || n_ren != 3) begin
            n_err++;
            $display("FAIL start_in_run: done=%b bits=%0d bad=%0d pops=%0d want 1/%0d/0/3",
                     s_done, got.size(), bad, n_ren, expq.size());
        end
        push_byte(8'hFF, 1'b1, 3'd0);
        pulse_start();
        repeat (4) tick();
        n_cmp++;
        if (!s_done || s_valid || n_ren != 3) begin
            n_err++;
            $display("FAIL start_in_done: done=%b valid=%b pops=%0d want 1/0/3", s_done, s_valid, n_ren);
        end
    endtask

    task automatic test_random();
        int nb, bad;
        for (int it = 0; it < 15; it++) begin
            reset_dut();
            rdy_mode  = $urandom_range(0, 2);
            stall_pct = 30 * $urandom_range(0, 1);
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++)
                push_byte(8'($urandom), (k == nb - 1), 3'($urandom_range(0, 7)));
            pulse_start();
            wait_done(600);
            bad = 0;
            for (int i = 0; i < got.size() && i < expq.size(); i++) if (got[i] != expq[i]) bad++;
            n_cmp++;
            if (!s_done || got.size() != expq.size() || bad != 0 || n_ren != nb
                || hold_err != 0 || underrun != 0) begin
                n_err++;
                $display("FAIL random_%0d: done=%b bits=%0d/%0d bad=%0d pops=%0d/%0d hold=%0d under=%0d",
                         it, s_done, got.size(), expq.size(), bad, n_ren, nb, hold_err, underrun);
            end
`ifdef NEXT_BIT_BITCNT_EN
            n_cmp++;
            if (bit_cnt !== 16'(expq.size())) begin
                n_err++;
                $display("FAIL random_bitcnt_%0d: got %0d want %0d", it, bit_cnt, expq.size());
            end
`endif
        end
    endtask

    initial begin
        n_rst = 1'b1; start = 1'b0; data = 8'd0; last = 1'b0; pad = '0;
        empty = 1'b1; b_ready = 1'b1; stall = 1'b0;
        rdy_mode = 0; stall_pct = 0;
        prev_v = 1'b0; prev_r = 1'b0; prev_b = 1'b0; prev_rst = 1'b1;
        test_reset();
        test_two_bytes();
        test_pad();
        test_backpressure();
        test_underflow();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
